// File: rtl/hilo_unit.sv
// HI/LO register file with single-cycle MTHI/MTLO/MULT/MADD/MSUB and a
// 32-step restoring divider that stalls the pipeline through Busy.
module hilo_unit #(
  parameter int DIV_CYCLES = 32
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [2:0]  HiLoOp,
  input  logic [63:0] Product,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] Hi,
  output logic [31:0] Lo,
  output logic        Busy,
  output logic        Done,
  output logic        DivByZero
);

  typedef enum logic [1:0] {IDLE, DIV_RUN, DIV_FIX} state_t;

  localparam logic [2:0] OP_MTHI = 3'b001;
  localparam logic [2:0] OP_MTLO = 3'b010;
  localparam logic [2:0] OP_MULT = 3'b011;
  localparam logic [2:0] OP_MADD = 3'b100;
  localparam logic [2:0] OP_MSUB = 3'b101;
  localparam logic [2:0] OP_DIV  = 3'b110;
  localparam logic [2:0] OP_DIVU = 3'b111;

  state_t      state, state_d;
  logic [31:0] hi_q, lo_q;
  logic [31:0] quo_q, rem_q, dvsr_q;
  logic        q_neg_q, r_neg_q;
  logic [5:0]  cnt_q;
  logic        done_q, dbz_q;

  logic        accept, is_div, is_signed;
  logic [31:0] a_mag, b_mag;
  logic [32:0] shifted, diff;
  logic        take;
  logic [63:0] hilo;

  assign accept    = Start && (state == IDLE) && (HiLoOp != 3'b000);
  assign is_div    = (HiLoOp == OP_DIV) || (HiLoOp == OP_DIVU);
  assign is_signed = (HiLoOp == OP_DIV);
  assign a_mag     = (is_signed && A[31]) ? -A : A;
  assign b_mag     = (is_signed && B[31]) ? -B : B;
  assign hilo      = {hi_q, lo_q};

  // Remainder stays below the divisor, so the trial subtraction needs one extra bit.
  assign shifted = {rem_q, quo_q[31]};
  assign diff    = shifted - {1'b0, dvsr_q};
  assign take    = shifted >= {1'b0, dvsr_q};

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (accept && is_div && (B != 32'd0)) state_d = DIV_RUN;
      DIV_RUN: if (cnt_q == 6'(DIV_CYCLES - 1)) state_d = DIV_FIX;
      DIV_FIX: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      hi_q    <= '0;
      lo_q    <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dvsr_q  <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            case (HiLoOp)
              OP_MTHI: hi_q <= A;
              OP_MTLO: lo_q <= A;
              OP_MULT: {hi_q, lo_q} <= Product;
              OP_MADD: {hi_q, lo_q} <= hilo + Product;
              OP_MSUB: {hi_q, lo_q} <= hilo - Product;
              default: begin
                quo_q   <= a_mag;
                rem_q   <= '0;
                dvsr_q  <= b_mag;
                q_neg_q <= is_signed && (A[31] ^ B[31]);
                r_neg_q <= is_signed && A[31];
                cnt_q   <= '0;
              end
            endcase
            // Division by zero completes immediately without touching HI/LO.
            if (!is_div || (B == 32'd0)) done_q <= 1'b1;
            if (is_div && (B == 32'd0))  dbz_q  <= 1'b1;
          end
        end
        DIV_RUN: begin
          rem_q <= take ? diff[31:0] : shifted[31:0];
          quo_q <= {quo_q[30:0], take};
          cnt_q <= cnt_q + 6'd1;
        end
        DIV_FIX: begin
          lo_q   <= q_neg_q ? -quo_q : quo_q;
          hi_q   <= r_neg_q ? -rem_q : rem_q;
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign Hi        = hi_q;
  assign Lo        = lo_q;
  assign Busy      = (state != IDLE);
  assign Done      = done_q;
  assign DivByZero = dbz_q;

endmodule

// File: tb/tb_hilo_unit.sv
// Directed bench for hilo_unit: a per-cycle compare against an arithmetic
// model of HI/LO plus a few hand-computed literal checkpoints.
module tb_hilo_unit;

  logic        Clk;
  logic        Reset;
  logic        Start;
  logic [2:0]  HiLoOp;
  logic [63:0] Product;
  logic [31:0] A, B;
  logic [31:0] Hi, Lo;
  logic        Busy, Done, DivByZero;

  hilo_unit dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .HiLoOp(HiLoOp),
    .Product(Product), .A(A), .B(B), .Hi(Hi), .Lo(Lo),
    .Busy(Busy), .Done(Done), .DivByZero(DivByZero)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int total = 0;
  int bad   = 0;

  // Model state: architectural HI/LO, pending division result and cycles left.
  logic [31:0] m_hi, m_lo, pend_hi, pend_lo;
  logic        m_done, m_dbz;
  int          busy_left;

  always @(posedge Clk or posedge Reset) begin
    longint sa, sb;
    logic [63:0] acc;
    if (Reset) begin
      m_hi = 0; m_lo = 0; m_done = 0; m_dbz = 0; busy_left = 0;
      pend_hi = 0; pend_lo = 0;
    end else begin
      m_done = 0;
      m_dbz  = 0;
      if (busy_left > 0) begin
        busy_left = busy_left - 1;
        if (busy_left == 0) begin
          m_hi = pend_hi; m_lo = pend_lo; m_done = 1;
        end
      end else if (Start && HiLoOp != 3'd0) begin
        acc = {m_hi, m_lo};
        case (HiLoOp)
          3'd1: begin m_hi = A; m_done = 1; end
          3'd2: begin m_lo = A; m_done = 1; end
          3'd3: begin {m_hi, m_lo} = Product; m_done = 1; end
          3'd4: begin {m_hi, m_lo} = acc + Product; m_done = 1; end
          3'd5: begin {m_hi, m_lo} = acc - Product; m_done = 1; end
          default: begin
            if (B == 0) begin
              m_done = 1; m_dbz = 1;
            end else begin
              if (HiLoOp == 3'd6) begin
                sa = longint'($signed(A));
                sb = longint'($signed(B));
              end else begin
                sa = longint'({32'd0, A});
                sb = longint'({32'd0, B});
              end
              pend_lo = 32'(sa / sb);
              pend_hi = 32'(sa % sb);
              busy_left = 33;
            end
          end
        endcase
      end
    end
  end

  // Literal checkpoints requested by the stimulus process.
  logic [31:0] lit_hi, lit_lo;
  logic        lit_busy;
  int          lit_seq  = 0;
  int          lit_seen = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge Clk) begin
    checkOutput("hi", Hi, m_hi);
    checkOutput("lo", Lo, m_lo);
    checkOutput("busy", {31'd0, Busy}, {31'd0, busy_left > 0});
    checkOutput("done", {31'd0, Done}, {31'd0, m_done});
    checkOutput("div_by_zero", {31'd0, DivByZero}, {31'd0, m_dbz});
    if (lit_seq != lit_seen) begin
      checkOutput("lit_hi", Hi, lit_hi);
      checkOutput("lit_lo", Lo, lit_lo);
      checkOutput("lit_busy", {31'd0, Busy}, {31'd0, lit_busy});
      lit_seen = lit_seq;
    end
  end

  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [63:0] prod);
    @(negedge Clk);
    Start = 1'b1; HiLoOp = op; A = a; B = b; Product = prod;
  endtask

  task automatic idleCycles(input int n);
    @(negedge Clk);
    Start = 1'b0; HiLoOp = 3'd0;
    repeat (n - 1) @(negedge Clk);
  endtask

  task automatic expectLit(input logic [31:0] hi, input logic [31:0] lo, input logic busy);
    lit_hi = hi; lit_lo = lo; lit_busy = busy;
    lit_seq++;
  endtask

  task automatic settle();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0; HiLoOp = 3'd0; Product = '0; A = '0; B = '0;
    repeat (3) @(negedge Clk);
    settle(); expectLit(32'h0, 32'h0, 1'b0);
    @(negedge Clk);
    Reset = 1'b0;

    // MTHI then MTLO on consecutive cycles
    applyStimulus(3'd1, 32'h12345678, 32'h0, 64'h0);
    applyStimulus(3'd2, 32'h9ABCDEF0, 32'h0, 64'h0);
    idleCycles(2);
    settle(); expectLit(32'h12345678, 32'h9ABCDEF0, 1'b0);

    // MULT / MADD carry into HI / MSUB borrow to all-ones
    applyStimulus(3'd3, 32'h0, 32'h0, 64'h00000001_FFFFFFFF);
    applyStimulus(3'd4, 32'h0, 32'h0, 64'h1);
    idleCycles(2);
    settle(); expectLit(32'h00000002, 32'h00000000, 1'b0);
    applyStimulus(3'd5, 32'h0, 32'h0, 64'h00000002_00000001);
    idleCycles(2);
    settle(); expectLit(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);

    // Signed and unsigned division of -7 by 2
    applyStimulus(3'd6, 32'hFFFFFFF9, 32'd2, 64'h0);
    idleCycles(1);
    repeat (34) @(negedge Clk);
    settle(); expectLit(32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    applyStimulus(3'd7, 32'hFFFFFFF9, 32'd2, 64'h0);
    idleCycles(36);
    settle(); expectLit(32'h00000001, 32'h7FFFFFFC, 1'b0);

    // Negative divisor: 7 / -2 = -3 rem 1
    applyStimulus(3'd6, 32'd7, 32'hFFFFFFFE, 64'h0);
    idleCycles(36);
    settle(); expectLit(32'h00000001, 32'hFFFFFFFD, 1'b0);

    // Overflow case, then unsigned divide by zero leaves HI/LO alone
    applyStimulus(3'd6, 32'h80000000, 32'hFFFFFFFF, 64'h0);
    idleCycles(36);
    settle(); expectLit(32'h00000000, 32'h80000000, 1'b0);
    applyStimulus(3'd7, 32'd5, 32'd0, 64'h0);
    idleCycles(3);
    settle(); expectLit(32'h00000000, 32'h80000000, 1'b0);

    // MTHI issued mid-division is dropped
    applyStimulus(3'd6, 32'd100, 32'd7, 64'h0);
    idleCycles(10);
    applyStimulus(3'd1, 32'hDEADBEEF, 32'h0, 64'h0);
    idleCycles(26);
    settle(); expectLit(32'd2, 32'd14, 1'b0);

    // Async reset mid-division clears everything without a clock edge
    applyStimulus(3'd6, 32'd100, 32'd3, 64'h0);
    idleCycles(15);
    @(posedge Clk);
    #1 Reset = 1'b1;
    expectLit(32'h0, 32'h0, 1'b0);
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    applyStimulus(3'd3, 32'h0, 32'h0, 64'd5);
    idleCycles(2);
    settle(); expectLit(32'h0, 32'h5, 1'b0);

    repeat (3) @(negedge Clk);
    @(posedge Clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hilo_unit.md
Name: hilo_unit

Overview:
HI/LO register file and multi-cycle divide unit for the MIPS datapath.
- Consumes the 64-bit signed product the ALU drives on its ALUResult bus for MULT/MADD/MSUB, and the rs/rt operands for MTHI/MTLO/DIV/DIVU.
- Owns architectural HI/LO and stalls the pipeline via Busy while an iterative division runs.
- Sits beside the ALU in EX; HI/LO outputs feed the MFHI/MFLO writeback mux.

Parameters:
DIV_CYCLES, 32, restoring-divide iterations (one quotient bit per cycle); fixed for 32-bit operands.

Ports:
Clk  input  1  system clock, rising edge
Reset  input  1  asynchronous, active-high; clears all state
Start  input  1  operation request; accepted on a rising edge when Busy=0
HiLoOp  input  3  operation: 000 NOP, 001 MTHI, 010 MTLO, 011 MULT, 100 MADD, 101 MSUB, 110 DIV, 111 DIVU
Product  input  64  signed product from the ALU (MULT path), valid in the Start cycle
A  input  32  rs operand (MTHI/MTLO source, dividend)
B  input  32  rt operand (divisor)
Hi  output  32  architectural HI
Lo  output  32  architectural LO
Busy  output  1  high while a division is in progress; the pipeline stalls EX
Done  output  1  one-cycle pulse when an accepted operation has updated HI/LO, or has finished without an update
DivByZero  output  1  one-cycle pulse, coincident with Done, when a DIV/DIVU had B=0

Behaviour:
- Reset (async, any time, including mid-division): Hi=0, Lo=0, Busy=0, Done=0, DivByZero=0, FSM=IDLE. Working registers are cleared and any division in progress is abandoned.
- FSM states: IDLE, DIV_RUN, DIV_FIX.
- Accept rule: an op is accepted at a rising edge where Start=1, Busy=0 and HiLoOp≠000. Start while Busy=1 is ignored; no queuing.
- Single-cycle ops, applied at the accepting edge; Done=1 for the following cycle:
  - MTHI: Hi<=A.
  - MTLO: Lo<=A.
  - MULT: {Hi,Lo}<=Product.
  - MADD: {Hi,Lo}<={Hi,Lo}+Product, modulo 2^64.
  - MSUB: {Hi,Lo}<={Hi,Lo}-Product, modulo 2^64.
- DIV/DIVU with B≠0:
  - At the accepting edge N, latch |A|,|B| (raw values for DIVU) and the result signs. FSM->DIV_RUN; Busy=1 from after edge N.
  - DIV_RUN: one restoring step per edge, edges N+1..N+32, using internal 32-bit quotient/remainder registers. Hi/Lo hold their old values throughout.
  - Edge N+33 (DIV_FIX): apply sign correction and write Lo=quotient, Hi=remainder. Busy->0, Done=1 for one cycle, FSM->IDLE.
  - Total: Busy high for exactly 33 cycles. A new Start can be accepted at edge N+34.
- Signed rules:
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives Lo=0x80000000, Hi=0 (wraps, no flag).
- Division by zero: at the accepting edge, Hi/Lo are unchanged and no Busy is raised. Done=1 and DivByZero=1 for the next cycle.
- Done and DivByZero are registered and deassert after one cycle unless a new op completes.
- Product is sampled only for MULT/MADD/MSUB; A/B are ignored for MULT/MADD/MSUB.

Test Plan:
- Reset then MTHI A=0x12345678, next cycle MTLO A=0x9ABCDEF0 -> Hi=0x12345678, Lo=0x9ABCDEF0; Done pulses twice; Busy stays 0.
- MULT Product=0x00000001_FFFFFFFF, then MADD Product=0x1 -> {Hi,Lo}=0x00000002_00000000. Then MSUB Product=0x00000002_00000001 -> {Hi,Lo}=0xFFFFFFFF_FFFFFFFF.
- DIV A=-7 (0xFFFFFFF9), B=2 -> Busy high 33 cycles, then Lo=0xFFFFFFFD (-3), Hi=0xFFFFFFFF (-1), one Done pulse. DIVU with the same operands -> Lo=0x7FFFFFFC, Hi=0x1.
- DIV A=0x80000000, B=0xFFFFFFFF -> Lo=0x80000000, Hi=0. Then DIVU A=5, B=0 -> Hi/Lo unchanged, Busy never rises, Done and DivByZero pulse together.
- Start DIV, pulse MTHI Start at cycle 10 of Busy -> MTHI ignored; division result correct; Hi=remainder.
- Start DIV A=100, B=3; assert Reset asynchronously at cycle 15 -> Hi=Lo=0, Busy=0 immediately. After release, MULT Product=5 -> Lo=5, Hi=0.
